// File: rtl/grapheme_lb_pkg.sv
`default_nettype none
// =============================================================================
// Module      : grapheme_lb_pkg
// Description : Shared types and constants for the grapheme local-bus master
//               and decoder.
// Revision    : 1.0 - initial release
// =============================================================================
package grapheme_lb_pkg;

    localparam int                     GRAPHEME_LB_DATA_W          = 32;
    localparam int                     GRAPHEME_LB_ADDR_W          = 4;
    localparam logic [GRAPHEME_LB_DATA_W-1:0] GRAPHEME_LB_DEFAULT_REG_VAL = 32'hdeadbabe;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lb_mstr_state_t;

    typedef struct packed {
        logic                          rd;
        logic [GRAPHEME_LB_ADDR_W-1:0] addr;
        logic [GRAPHEME_LB_DATA_W-1:0] wdata;
    } lb_cmd_t;

endpackage : grapheme_lb_pkg
`default_nettype wire

// File: rtl/grapheme_lb_master_if.sv
`default_nettype none
// =============================================================================
// Module      : grapheme_lb_master_if
// Description : Command/response handshakes and local-bus signals of the
//               grapheme LB master; master = initiator view.
// Revision    : 1.0 - initial release
// =============================================================================
interface grapheme_lb_master_if
    import grapheme_lb_pkg::*;
#(
    parameter int LB_DATA_W = GRAPHEME_LB_DATA_W,
    parameter int LB_ADDR_W = GRAPHEME_LB_ADDR_W
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_rd;
    logic [LB_ADDR_W-1:0] cmd_addr;
    logic [LB_DATA_W-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [LB_DATA_W-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 lb_wr_en;
    logic                 lb_rd_en;
    logic [LB_ADDR_W-1:0] lb_addr;
    logic [LB_DATA_W-1:0] lb_wr_data;
    logic                 lb_wr_valid;
    logic                 lb_rd_valid;
    logic [LB_DATA_W-1:0] lb_rd_data;

    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
        input  lb_wr_valid, lb_rd_valid, lb_rd_data
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
        output lb_wr_valid, lb_rd_valid, lb_rd_data
    );

endinterface : grapheme_lb_master_if
`default_nettype wire

// File: rtl/grapheme_lb_master.sv
`default_nettype none
// =============================================================================
// Module      : grapheme_lb_master
// Description : Single-outstanding local-bus initiator: command handshake in,
//               one-cycle LB strobe out, acknowledge wait, response handshake.
//               Define GRAPHEME_LB_MASTER_TIMEOUT_EN to compile in the
//               acknowledge timeout.
// Revision    : 1.0 - initial release
// =============================================================================
module grapheme_lb_master
    import grapheme_lb_pkg::*;
#(
    parameter int                   LB_DATA_W       = GRAPHEME_LB_DATA_W,
    parameter int                   LB_ADDR_W       = GRAPHEME_LB_ADDR_W,
    parameter int                   TIMEOUT_CYCLES  = 16,
    parameter logic [LB_DATA_W-1:0] DEFAULT_REG_VAL = GRAPHEME_LB_DEFAULT_REG_VAL
) (
    input  wire logic             clk,
    input  wire logic             rst,
    grapheme_lb_master_if.master  bus
);

    lb_mstr_state_t       r_state;
    lb_cmd_t              r_cmd;
    logic                 r_cmd_ready;
    logic                 r_rsp_valid;
    logic [LB_DATA_W-1:0] r_rsp_rdata;
    logic                 r_wr_en;
    logic                 r_rd_en;
    logic                 w_ack;

    // Only the acknowledge matching the outstanding command type counts.
    assign w_ack = r_cmd.rd ? bus.lb_rd_valid : bus.lb_wr_valid;

`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
    localparam int                   CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]     c_CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]                r_wait_cnt;
    logic                            r_rsp_err;

    assign bus.rsp_err = r_rsp_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{DEFAULT_REG_VAL, TIMEOUT_CYCLES[0]};
    assign bus.rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Strobe is registered here so it is visible exactly during ISSUE.
                    if (bus.cmd_valid) begin
                        r_cmd       <= '{rd: bus.cmd_rd, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
                        r_wr_en     <= ~bus.cmd_rd;
                        r_rd_en     <= bus.cmd_rd;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_cmd.rd ? bus.lb_rd_data : '0;
`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ST_RESP;
                    end
`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
                    // The last counted WAIT cycle still honours a matching ack.
                    else if (r_wait_cnt == c_CNT_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_cmd.rd ? DEFAULT_REG_VAL : '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.lb_wr_en   = r_wr_en;
    assign bus.lb_rd_en   = r_rd_en;
    assign bus.lb_addr    = r_cmd.addr;
    assign bus.lb_wr_data = r_cmd.wdata;

endmodule : grapheme_lb_master
`default_nettype wire

// File: tb/tb_grapheme_lb_master.sv
`default_nettype none
// =============================================================================
// Module      : tb_grapheme_lb_master
// Description : Self-checking bench for grapheme_lb_master with a timeline
//               model of the transaction and a small LB decoder model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_grapheme_lb_master;
    import grapheme_lb_pkg::*;

    localparam int c_T = 16;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    bit   chk_en;

    grapheme_lb_master_if #(.LB_DATA_W(32), .LB_ADDR_W(4)) bus ();

    grapheme_lb_master #(
        .LB_DATA_W      (32),
        .LB_ADDR_W      (4),
        .TIMEOUT_CYCLES (c_T),
        .DEFAULT_REG_VAL(32'hdeadbabe)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decoder model: 0 = ack one cycle after strobe, 1 = never ack, 2 = wrong ack type
    int          mode;
    int          late_ack_cyc;
    logic [31:0] mem [16];
    logic        s_wr, s_rd;
    logic [3:0]  s_addr;
    logic [31:0] s_data;

    always begin
        @(posedge clk);
        s_wr   = bus.lb_wr_en;
        s_rd   = bus.lb_rd_en;
        s_addr = bus.lb_addr;
        s_data = bus.lb_wr_data;
        #1;
        if (s_wr === 1'b1) mem[s_addr] = s_data;
        bus.lb_wr_valid = (mode == 0 && s_wr === 1'b1) || (mode == 2 && s_rd === 1'b1);
        bus.lb_rd_valid = (mode == 0 && s_rd === 1'b1) || (cyc == late_ack_cyc);
        bus.lb_rd_data  = bus.lb_rd_valid ? mem[bus.lb_addr] : 32'h0;
    end

    // Transaction timeline model: strobe one cycle after the command handshake,
    // matching ack accepted from two cycles after it, response the cycle after.
    bit          m_busy = 0, m_rsp = 0, m_fresh = 1, m_rd = 0, m_err = 0;
    int          m_hs = 0;
    logic [3:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", bus.cmd_ready, !m_busy);
            chk("rsp_valid", bus.rsp_valid, m_rsp);
            if (m_rsp || m_fresh) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err", bus.rsp_err, m_err);
            end
            chk("lb_wr_en", bus.lb_wr_en, m_busy && !m_rd && cyc == m_hs + 1);
            chk("lb_rd_en", bus.lb_rd_en, m_busy && m_rd && cyc == m_hs + 1);
            chk("lb_addr", bus.lb_addr, m_addr);
            chk("lb_wr_data", bus.lb_wr_data, m_wdata);
        end
        if (rst) begin
            m_busy = 0; m_rsp = 0; m_fresh = 1; m_err = 0;
            m_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (!m_busy) begin
            if (bus.cmd_valid) begin
                m_busy = 1; m_hs = cyc; m_rd = bus.cmd_rd;
                m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata;
            end
        end else if (m_rsp) begin
            if (bus.rsp_ready) begin
                m_rsp = 0; m_busy = 0;
            end
        end else if (cyc >= m_hs + 2) begin
            if (m_rd ? bus.lb_rd_valid : bus.lb_wr_valid) begin
                m_rsp = 1; m_fresh = 0; m_err = 0;
                m_rdata = m_rd ? bus.lb_rd_data : 32'h0;
            end
`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
            else if (cyc == m_hs + 1 + c_T) begin
                m_rsp = 1; m_fresh = 0; m_err = 1;
                m_rdata = m_rd ? 32'hdeadbabe : 32'h0;
            end
`endif
        end
    end

    int last_rsp_hs;

    task automatic wait_cmd_hs(output int hs);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("cmd_hs_timeout", 32'd0, 32'd1);
        hs = cyc;
    endtask

    task automatic do_cmd(input bit rd, input logic [3:0] a, input logic [31:0] d, input int bp,
                          output logic [31:0] rdata, output logic err, output int lat, output int hs);
        int n;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_rd = rd; bus.cmd_addr = a; bus.cmd_wdata = d;
        if (bp > 0) bus.rsp_ready = 1'b0;
        wait_cmd_hs(hs);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("strobe", rd ? bus.lb_rd_en : bus.lb_wr_en, 32'd1);
        chk("strobe_addr", bus.lb_addr, a);
        chk("strobe_data", bus.lb_wr_data, d);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rsp_wait_timeout", 32'd0, 32'd1);
        lat = cyc - hs; rdata = bus.rsp_rdata; err = bus.rsp_err;
        if (bp > 0) begin
            repeat (bp - 1) @(negedge clk);
            @(posedge clk); #1;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        last_rsp_hs = cyc;
    endtask

    task automatic rst_during(input int offset);
        int hs;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_rd = 1'b1; bus.cmd_addr = 4'd3; bus.cmd_wdata = 32'h55;
        wait_cmd_hs(hs);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int i = 1; i < offset; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
        chk("rst_cmd_ready", bus.cmd_ready, 32'd1);
        chk("rst_rd_en", bus.lb_rd_en, 32'd0);
        chk("rst_lb_addr", bus.lb_addr, 32'd0);
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat, hs, prev;

    initial begin
        tests = 0; fails = 0; chk_en = 0; cyc = 0;
        mode = 0; late_ack_cyc = -1;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        mem[3] = 32'h0000_00a5;
        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_rd = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.lb_wr_valid = 0; bus.lb_rd_valid = 0; bus.lb_rd_data = '0;
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Write with one-cycle ack: response three cycles after the handshake
        do_cmd(1'b0, 4'd2, 32'd3, 0, rdata, err, lat, hs);
        chk("wr_lat", lat, 32'd3); chk("wr_rdata", rdata, 32'd0); chk("wr_err", err, 32'd0);
        prev = last_rsp_hs;

        do_cmd(1'b1, 4'd3, 32'd0, 0, rdata, err, lat, hs);
        chk("b2b_gap", hs - prev, 32'd1);
        chk("rd_lat", lat, 32'd3); chk("rd_rdata", rdata, 32'h0000_00a5); chk("rd_err", err, 32'd0);

        // Response backpressure for five cycles, then back-to-back write
        do_cmd(1'b1, 4'd2, 32'hffff_0000, 5, rdata, err, lat, hs);
        chk("bp_lat", lat, 32'd3); chk("bp_rdata", rdata, 32'd3);
        prev = last_rsp_hs;
        do_cmd(1'b0, 4'd4, 32'h1, 0, rdata, err, lat, hs);
        chk("bp_b2b_gap", hs - prev, 32'd1);

        // Wrong ack type is ignored; a later read ack completes the read
        mode = 2;
        late_ack_cyc = cyc + 8;
        do_cmd(1'b1, 4'd3, 32'd0, 0, rdata, err, lat, hs);
        chk("wrong_ack_lat", lat, 32'd8); chk("wrong_ack_rdata", rdata, 32'h0000_00a5);
        chk("wrong_ack_err", err, 32'd0);
        mode = 0;

`ifdef GRAPHEME_LB_MASTER_TIMEOUT_EN
        mode = 1;
        do_cmd(1'b1, 4'd5, 32'd0, 0, rdata, err, lat, hs);
        chk("to_rd_lat", lat, c_T + 2); chk("to_rd_err", err, 32'd1);
        chk("to_rd_rdata", rdata, 32'hdeadbabe);
        late_ack_cyc = cyc + 2;
        repeat (5) @(negedge clk);
        chk("late_ack_rsp_valid", bus.rsp_valid, 32'd0);
        chk("late_ack_cmd_ready", bus.cmd_ready, 32'd1);
        do_cmd(1'b0, 4'd6, 32'h77, 0, rdata, err, lat, hs);
        chk("to_wr_err", err, 32'd1); chk("to_wr_rdata", rdata, 32'd0);
        mode = 0;
`endif

        // Reset during WAIT and during the strobe cycle drops the transaction
        mode = 1;
        rst_during(3);
        rst_during(1);
        mode = 0;

        do_cmd(1'b0, 4'd7, 32'h1234_5678, 0, rdata, err, lat, hs);
        chk("post_rst_wr_lat", lat, 32'd3);
        do_cmd(1'b1, 4'd7, 32'd0, 0, rdata, err, lat, hs);
        chk("post_rst_rd_rdata", rdata, 32'h1234_5678); chk("post_rst_rd_err", err, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_grapheme_lb_master
`default_nettype wire
